// File: rtl/riscv_pkg.sv
// RV M-extension operation encoding and the multiply/divide FSM state type.
package riscv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } f3_muldiv_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/tartaruga_pkg.sv
// XLEN-generic constants shared by the tartaruga core blocks.
package tartaruga_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int TAG_W_DEFAULT = 5;

  // Width of a counter that walks one iteration per operand bit.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between an issuing pipeline and the mul/div unit.
interface riscv_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] tag;
  logic             kill;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, funct3, rs1, rs2, tag, kill, rsp_ready,
    input  req_ready, rsp_valid, result, rsp_tag
  );

  modport slave (
    input  req_valid, funct3, rs1, rs2, tag, kill, rsp_ready,
    output req_ready, rsp_valid, result, rsp_tag
  );

endinterface

// File: rtl/riscv_muldiv_iter.sv
// Shared radix-2 iteration datapath: shift-add multiply and, with
// RISCV_MULDIV_DIV_EN defined, restoring divide on the same hi/lo registers.
module riscv_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            step,
`ifdef RISCV_MULDIV_DIV_EN
  input  logic            div_mode,
`endif
  input  logic [XLEN-1:0] load_hi,
  input  logic [XLEN-1:0] load_lo,
  input  logic [XLEN-1:0] load_opnd,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] hi_next;
  logic [XLEN-1:0] lo_next;
`ifdef RISCV_MULDIV_DIV_EN
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
`endif

  // Multiply: add multiplicand when lo[0] is set, then shift {carry,hi,lo} right.
  // Divide: shift the dividend MSB into the remainder and keep it if the trial
  // subtraction does not borrow.
  always_comb begin
    sum     = {1'b0, hi} + ({1'b0, opnd} & {(XLEN+1){lo[0]}});
    hi_next = sum[XLEN:1];
    lo_next = {sum[0], lo[XLEN-1:1]};
`ifdef RISCV_MULDIV_DIV_EN
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (div_mode) begin
      hi_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ~diff[XLEN]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (load) begin
      hi   <= load_hi;
      lo   <= load_lo;
      opnd <= load_opnd;
    end else if (step) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV M-extension unit: FSM, sign handling and handshake around the
// shared iteration datapath. Divider present only with RISCV_MULDIV_DIV_EN.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN  = tartaruga_pkg::XLEN_DEFAULT,
  parameter int TAG_W = tartaruga_pkg::TAG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = tartaruga_pkg::cnt_width(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  muldiv_state_t    state, state_next;
  f3_muldiv_t       op_in, op_q;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q;
  logic             accept, is_mul_in, div_signed, signed_a, signed_b;
  logic             a_neg, b_neg, neg_in, special_in;
  logic             iter_step;
  logic [XLEN-1:0]  mag1, mag2, load_hi, load_lo, load_opnd, hi, lo;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign op_in      = f3_muldiv_t'(funct3_i);
  assign is_mul_in  = ~funct3_i[2];
  assign div_signed = (op_in == F3_DIV) || (op_in == F3_REM);
  assign signed_a   = is_mul_in ? (op_in != F3_MULHU) : div_signed;
  assign signed_b   = is_mul_in ? ((op_in == F3_MUL) || (op_in == F3_MULH)) : div_signed;
  assign a_neg      = signed_a & rs1_i[XLEN-1];
  assign b_neg      = signed_b & rs2_i[XLEN-1];
  assign mag1       = a_neg ? -rs1_i : rs1_i;
  assign mag2       = b_neg ? -rs2_i : rs2_i;
  // Remainders follow the dividend's sign; everything else takes the XOR.
  assign neg_in     = (!is_mul_in && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
  assign accept     = valid_i && ready_o && !kill_i;

`ifdef RISCV_MULDIV_DIV_EN
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic div_zero, div_ovf, special_q;
  assign div_zero   = (rs2_i == '0);
  assign div_ovf    = div_signed && (rs1_i == XMIN) && (rs2_i == '1);
  assign special_in = !is_mul_in && (div_zero || div_ovf);
`else
  assign special_in = !is_mul_in;
`endif

  // Special-case divides preload their final answer so DONE can show it unchanged.
  always_comb begin
    load_hi   = '0;
    load_lo   = mag2;
    load_opnd = mag1;
    if (!is_mul_in) begin
`ifdef RISCV_MULDIV_DIV_EN
      load_lo   = mag1;
      load_opnd = mag2;
      if (div_zero) begin
        load_hi = rs1_i;
        load_lo = '1;
      end else if (div_ovf) begin
        load_lo = XMIN;
      end
`else
      load_lo = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = is_mul_in ? MUL : (special_in ? DONE : DIV);
      MUL, DIV: if (cnt == LAST_STEP) state_next = DONE;
      DONE:     if (ready_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (kill_i) state_next = IDLE;
  end

  always_comb begin
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    iter_step = 1'b0;
    case (state)
      IDLE:     ready_o   = 1'b1;
      MUL, DIV: iter_step = 1'b1;
      DONE:     valid_o   = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt   <= '0;
      op_q  <= F3_MUL;
      neg_q <= 1'b0;
      tag_q <= '0;
`ifdef RISCV_MULDIV_DIV_EN
      special_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt   <= '0;
        op_q  <= op_in;
        neg_q <= neg_in;
        tag_q <= tag_i;
`ifdef RISCV_MULDIV_DIV_EN
        special_q <= special_in;
`endif
      end else if (iter_step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (kill_i) cnt <= '0;
    end
  end

  riscv_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .load      (accept),
    .step      (iter_step),
`ifdef RISCV_MULDIV_DIV_EN
    .div_mode  (state == DIV),
`endif
    .load_hi   (load_hi),
    .load_lo   (load_lo),
    .load_opnd (load_opnd),
    .hi        (hi),
    .lo        (lo)
  );

  assign prod     = {hi, lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign tag_o    = tag_q;

  always_comb begin
    result_o = '0;
    case (op_q)
      F3_MUL:                       result_o = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
`ifdef RISCV_MULDIV_DIV_EN
      F3_DIV, F3_DIVU:              result_o = (neg_q && !special_q) ? -lo : lo;
      F3_REM, F3_REMU:              result_o = (neg_q && !special_q) ? -hi : hi;
`endif
      default:                      result_o = '0;
    endcase
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv at XLEN=32; divide expectations
// follow RISCV_MULDIV_DIV_EN.
module tb_riscv_muldiv;
  import riscv_pkg::*;

`ifdef RISCV_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_LAT = DIV_EN ? 33 : 1;

  typedef struct {
    f3_muldiv_t  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  riscv_muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

  riscv_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .valid_i  (bus.req_valid),
    .ready_o  (bus.req_ready),
    .funct3_i (bus.funct3),
    .rs1_i    (bus.rs1),
    .rs2_i    (bus.rs2),
    .tag_i    (bus.tag),
    .kill_i   (bus.kill),
    .valid_o  (bus.rsp_valid),
    .ready_i  (bus.rsp_ready),
    .result_o (bus.result),
    .tag_o    (bus.rsp_tag)
  );

  // Waits for ready_o, presents one request for exactly one edge.
  task automatic send(input f3_muldiv_t f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t);
    int guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.funct3    = f3;
    bus.rs1       = a;
    bus.rs2       = b;
    bus.tag       = t;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Latency in cycles from the accept cycle to the first cycle valid_o is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.kill = 1'b0; bus.rsp_ready = 1'b0;
    bus.funct3 = 3'b000; bus.rs1 = '0; bus.rs2 = '0; bus.tag = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.rsp_valid); end
    if (bus.result !== 32'h0)   begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
    if (bus.rsp_tag !== 5'h0)   begin errors++; $display("[TB] FAIL reset_tag: got %h expected 0", bus.rsp_tag); end
    #3 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_vectors(input string name, input vec_t v[6]);
    int lat;
    for (int i = 0; i < 6; i++) begin
      send(v[i].f3, v[i].a, v[i].b, 5'(i + 3));
      wait_result(lat);
      checks += 3;
      if (bus.result !== v[i].exp) begin
        errors++; $display("[TB] FAIL %s[%0d] result: got %h expected %h", name, i, bus.result, v[i].exp);
      end
      if (lat != v[i].lat) begin
        errors++; $display("[TB] FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, v[i].lat);
      end
      if (bus.rsp_tag !== 5'(i + 3)) begin
        errors++; $display("[TB] FAIL %s[%0d] tag: got %h expected %h", name, i, bus.rsp_tag, 5'(i + 3));
      end
      take();
    end
  endtask

  task automatic test_mul();
    vec_t v[6];
    v[0] = '{F3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    v[1] = '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    v[2] = '{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33};
    v[3] = '{F3_MUL,    32'h12345678,   32'h00000010, 32'h23456780, 33};
    v[4] = '{F3_MULHSU, 32'hFFFFFFFF,   32'h00000002, 32'hFFFFFFFF, 33};
    v[5] = '{F3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33};
    run_vectors("mul", v);
  endtask

  task automatic test_div();
    vec_t v[6];
    v[0] = '{F3_DIV,  32'hFFFFFFF9, 32'd2,        DIV_EN ? 32'hFFFFFFFD : 32'h0, DIV_LAT};
    v[1] = '{F3_REM,  32'hFFFFFFF9, 32'd2,        DIV_EN ? 32'hFFFFFFFF : 32'h0, DIV_LAT};
    v[2] = '{F3_DIVU, 32'd100,      32'd7,        DIV_EN ? 32'd14       : 32'h0, DIV_LAT};
    v[3] = '{F3_REMU, 32'd100,      32'd7,        DIV_EN ? 32'd2        : 32'h0, DIV_LAT};
    v[4] = '{F3_REM,  32'd7,        32'hFFFFFFFE, DIV_EN ? 32'd1        : 32'h0, DIV_LAT};
    v[5] = '{F3_REMU, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'h0, DIV_LAT};
    run_vectors("div", v);
  endtask

  task automatic test_div_special();
    vec_t v[6];
    v[0] = '{F3_DIVU, 32'd5,        32'd0,        DIV_EN ? 32'hFFFFFFFF : 32'h0, 1};
    v[1] = '{F3_DIV,  32'h80000000, 32'hFFFFFFFF, DIV_EN ? 32'h80000000 : 32'h0, 1};
    v[2] = '{F3_REM,  32'd5,        32'd0,        DIV_EN ? 32'd5        : 32'h0, 1};
    v[3] = '{F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,                         1};
    v[4] = '{F3_DIV,  32'hFFFFFFFB, 32'd0,        DIV_EN ? 32'hFFFFFFFF : 32'h0, 1};
    v[5] = '{F3_REMU, 32'hFFFFFFFB, 32'd0,        DIV_EN ? 32'hFFFFFFFB : 32'h0, 1};
    run_vectors("divspec", v);
  endtask

  task automatic test_hold();
    int lat;
    send(F3_MUL, 32'd3, 32'd5, 5'd9);
    wait_result(lat);
    checks++;
    if (lat != 33) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected 33", lat); end
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks += 4;
      if (bus.rsp_valid !== 1'b1)  begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, bus.rsp_valid); end
      if (bus.result !== 32'd15)   begin errors++; $display("[TB] FAIL hold_result[%0d]: got %h expected f", i, bus.result); end
      if (bus.rsp_tag !== 5'd9)    begin errors++; $display("[TB] FAIL hold_tag[%0d]: got %h expected 9", i, bus.rsp_tag); end
      if (bus.req_ready !== 1'b0)  begin errors++; $display("[TB] FAIL hold_ready[%0d]: got %b expected 0", i, bus.req_ready); end
    end
    take();
    bus.req_valid = 1'b0;
    checks += 2;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_kill();
    bit seen;
    send(F3_MUL, 32'd11, 32'd13, 5'd4);
    repeat (4) begin @(posedge clk); #1; end
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    checks += 2;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_ready: got %b expected 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_valid: got %b expected 0", bus.rsp_valid); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL kill_no_result: got 1 expected 0"); end
    bus.funct3 = F3_MUL; bus.rs1 = 32'd1; bus.rs2 = 32'd1;
    bus.req_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.kill = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_vs_accept_ready: got %b expected 1", bus.req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL kill_vs_accept_result: got 1 expected 0"); end
  endtask

  task automatic test_kill_done();
    int lat;
    send(F3_MULHU, 32'd2, 32'd3, 5'd6);
    wait_result(lat);
    bus.kill = 1'b1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.rsp_ready = 1'b0;
    checks += 2;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL kill_done_valid: got %b expected 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_done_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    send(F3_DIVU, 32'd100, 32'd7, 5'd7);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    checks += 4;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus.rsp_valid); end
    if (bus.result !== 32'h0)   begin errors++; $display("[TB] FAIL midrst_result: got %h expected 0", bus.result); end
    if (bus.rsp_tag !== 5'h0)   begin errors++; $display("[TB] FAIL midrst_tag: got %h expected 0", bus.rsp_tag); end
    #1 rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1 || bus.req_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL midrst_discarded: got 1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17);
    wait_result(lat);
    checks += 2;
    if (bus.result !== 32'h1)    begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected 1", bus.result); end
    if (bus.rsp_tag !== 5'd17)   begin errors++; $display("[TB] FAIL b2b_first_tag: got %h expected 11", bus.rsp_tag); end
    take();
    send(F3_MULHU, 32'h80000000, 32'h00000004, 5'd30);
    wait_result(lat);
    checks += 3;
    if (bus.result !== 32'h2)    begin errors++; $display("[TB] FAIL b2b_second_result: got %h expected 2", bus.result); end
    if (bus.rsp_tag !== 5'd30)   begin errors++; $display("[TB] FAIL b2b_second_tag: got %h expected 1e", bus.rsp_tag); end
    if (lat != 33)               begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 33", lat); end
    take();
  endtask

  initial begin
    $display("[TB] riscv_muldiv bench, divider %s", DIV_EN ? "enabled" : "disabled");
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_hold();
    test_kill();
    test_kill_done();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width, even and at least 8.
REQ-002 SHALL have parameter TAG_W, default 5: width of the destination-register tag.
REQ-003 SHALL have port clk_i, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i, input, 1: request present.
REQ-006 SHALL have port ready_o, output, 1: unit can accept a request.
REQ-007 SHALL have port funct3_i, input, 3: operation, encoded as f3_muldiv_t.
REQ-008 SHALL have ports rs1_i and rs2_i, input, XLEN: operands.
REQ-009 SHALL have port tag_i, input, TAG_W: destination tag, returned with the result.
REQ-010 SHALL have port kill_i, input, 1: pipeline flush.
REQ-011 SHALL have port valid_o, output, 1: result present.
REQ-012 SHALL have port ready_i, input, 1: consumer accepts the result.
REQ-013 SHALL have port result_o, output, XLEN: result.
REQ-014 SHALL have port tag_o, output, TAG_W: tag captured at accept.

Function
REQ-015 SHALL implement RV M-extension semantics for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
REQ-016 SHALL use FSM states IDLE, MUL, DIV and DONE.
REQ-017 SHALL assert ready_o only in IDLE; a request is accepted on valid_i && ready_o && !kill_i, latching funct3_i, rs1_i, rs2_i and tag_i.
REQ-018 SHALL, for MUL-family ops, use radix-2 shift-add on operand magnitudes with the sign applied at the end; MUL state lasts exactly XLEN cycles, then DONE.
REQ-019 SHALL, for DIV-family ops, use radix-2 restoring division on magnitudes; DIV state lasts exactly XLEN cycles, then DONE.
REQ-020 SHALL apply result sign rules: quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-021 SHALL handle divide by zero by skipping DIV and entering DONE the cycle after accept, with quotient all-ones and remainder = rs1.
REQ-022 SHALL handle signed overflow (rs1 = MIN, rs2 = -1, DIV/REM) by skipping DIV, with quotient = MIN and remainder = 0.
REQ-023 SHALL, in DONE, assert valid_o and hold result_o and tag_o stable until ready_i is sampled high, then move to IDLE; no back-to-back accept in the same cycle.
REQ-024 SHALL, on kill_i high in any state, move to IDLE on the next edge, deassert valid_o and discard in-flight state; kill_i wins over a simultaneous accept or ready_i.
REQ-025 SHALL return the low XLEN bits for MUL and the high XLEN bits of the 2*XLEN product for MULH, MULHSU and MULHU.

Reset
REQ-026 SHALL, on rstn_i low, asynchronously enter IDLE with ready_o=1, valid_o=0, result_o=0, tag_o=0 and counters cleared; a reset mid-operation discards the operation.

Configuration
REQ-027 SHALL, with macro RISCV_MULDIV_DIV_EN defined, implement the DIV state and REQ-019 to REQ-022.
REQ-028 SHALL, with RISCV_MULDIV_DIV_EN undefined, contain no divider logic; DIV-family requests go to DONE the cycle after accept with result_o = 0.

Structure
REQ-029 SHALL take f3_muldiv_t (MUL=000 ... REMU=111) and muldiv_state_t from riscv_pkg, with XLEN-generic constants in tartaruga_pkg.
REQ-030 SHALL place the shared shift/add-subtract iteration datapath in sub-module riscv_muldiv_iter; the FSM, sign fix-up and handshake stay in riscv_muldiv.

Verification (XLEN=32)
REQ-031 SHALL cover: MUL 7 x -3 -> result 0xFFFFFFEB, valid_o 33 cycles after accept.
REQ-032 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH of the same operands -> result 0x00000000.
REQ-033 SHALL cover: DIV -7 / 2 -> result 0xFFFFFFFD; REM -7 / 2 -> result 0xFFFFFFFF.
REQ-034 SHALL cover: DIVU 5 / 0 -> result 0xFFFFFFFF; DIV 0x80000000 / -1 -> result 0x80000000; both with valid_o 1 cycle after accept.
REQ-035 SHALL cover: ready_i held low 10 cycles in DONE -> valid_o, result_o and tag_o stable, and ready_o stays 0.
REQ-036 SHALL cover: kill_i in cycle 5 of MUL -> valid_o never rises and ready_o=1 the next cycle; rstn_i pulsed during DIV -> outputs at reset values.
